// File: rtl/aes_pkg.sv
// AES-128 arithmetic shared by the encryptor and decryptor:
// GF(2^8) helpers, S-boxes, round constants and key-schedule steps.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} dec_fsm_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        byte_t b;
        r = 8'h01;
        b = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, b);
            b = gf_mul(b, b);
        end
        return r;
    endfunction

    function automatic byte_t rotl8(input byte_t x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3)
                 ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t sub_rot_word(input word_t w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic state_t key_step_fwd(input state_t k, input byte_t rc);
        word_t n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic state_t key_step_inv(input state_t k, input byte_t rc);
        word_t b0, b1, b2, b3;
        b1 = k[127:96] ^ k[95:64];
        b2 = k[95:64] ^ k[63:32];
        b3 = k[63:32] ^ k[31:0];
        b0 = k[127:96] ^ sub_rot_word(b3) ^ {rc, 24'h0};
        return {b0, b1, b2, b3};
    endfunction

    function automatic word_t inv_mix_column(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    state_t t;

    always_comb begin
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(state_in[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        t = t ^ rk;
        state_out = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                state_out[127 - 32 * c -: 32] = inv_mix_column(t[127 - 32 * c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes128_decrypt_iterative.sv
// Iterative AES-128 inverse cipher: forward expansion to round key 10,
// then inverse rounds while stepping the key schedule backwards.
module aes128_decrypt_iterative
    import aes_pkg::*;
#(
    parameter bit USE_KEY_CACHE = 1'b1,
    parameter int NR            = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         key_reuse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    if (NR != aes_pkg::NR) begin : g_bad_nr
        $error("aes128_decrypt_iterative supports only NR = 10");
    end

    dec_fsm_t   fsm;
    logic [3:0] r;
    state_t     ct;
    state_t     rk;
    state_t     blk;
    state_t     cache;
    logic       cache_valid;
    state_t     next_rk;
    state_t     prev_rk;
    state_t     round_out;

    assign in_ready = (fsm == IDLE);
    assign busy     = (fsm != IDLE);
    assign next_rk  = key_step_fwd(rk, rcon(r + 4'd1));
    assign prev_rk  = key_step_inv(rk, rcon(r));

    aes_inv_round u_inv_round (
        .state_in  (blk),
        .rk        (prev_rk),
        .last      (r == 4'd1),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm         <= IDLE;
            r           <= '0;
            ct          <= '0;
            rk          <= '0;
            blk         <= '0;
            cache       <= '0;
            cache_valid <= 1'b0;
            out_valid   <= 1'b0;
            data_out    <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        if (USE_KEY_CACHE && key_reuse && cache_valid) begin
                            blk <= data_in ^ cache;
                            rk  <= cache;
                            r   <= 4'd10;
                            fsm <= ROUND;
                        end else begin
                            ct  <= data_in;
                            rk  <= key_in;
                            r   <= 4'd0;
                            fsm <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    rk <= next_rk;
                    r  <= r + 4'd1;
                    if (r == 4'd9) begin
                        blk         <= ct ^ next_rk;
                        cache       <= next_rk;
                        cache_valid <= 1'b1;
                        fsm         <= ROUND;
                    end
                end
                ROUND: begin
                    blk <= round_out;
                    rk  <= prev_rk;
                    r   <= r - 4'd1;
                    if (r == 4'd1) begin
                        data_out  <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iterative.sv
// Directed and randomised bench for aes128_decrypt_iterative,
// with an independent table-driven AES-128 encryptor as reference.
module tb_aes128_decrypt_iterative;

    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         key_reuse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    int tests;
    int fails;
    int hs_cnt;
    int exp_hs;

    aes128_decrypt_iterative dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .key_reuse (key_reuse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) hs_cnt++;
    end

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] k;
        logic [127:0] res;
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        k  = key;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ key[127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4 * c + r] = sb(s[4 * ((c + r) % 4) + r]);
            for (int c = 0; c < 4; c++) begin
                a0 = u[4 * c]; a1 = u[4 * c + 1]; a2 = u[4 * c + 2]; a3 = u[4 * c + 3];
                if (rnd != 10) begin
                    s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            t = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rc, 24'h0};
            k[127:96] = k[127:96] ^ t;
            k[95:64]  = k[95:64] ^ k[127:96];
            k[63:32]  = k[63:32] ^ k[95:64];
            k[31:0]   = k[31:0] ^ k[63:32];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic job(input string tag, input logic [127:0] ct, input logic [127:0] k,
                       input logic reuse, input logic [127:0] exp_pt,
                       input int exp_lat, input int stall);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, 128'(in_ready), 128'(1'b1));
        in_valid  = 1'b1;
        data_in   = ct;
        key_in    = k;
        key_reuse = reuse;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        key_reuse = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " data"}, data_out, exp_pt);
        exp_hs++;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk({tag, " held valid"}, 128'(out_valid), 128'(1'b1));
            chk({tag, " held data"}, data_out, exp_pt);
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, " released"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, k, kin, cache_key;
        logic         reuse;
        int           lat;
        int           elat;
        tests = 0; fails = 0; hs_cnt = 0; exp_hs = 0;
        reset = 1'b1; in_valid = 1'b0; data_in = '0; key_in = '0;
        key_reuse = 1'b0; out_ready = 1'b1;

        chk("model c1", enc(C1_KEY, C1_PT), C1_CT);
        chk("model appb", enc(B_KEY, B_PT), B_CT);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst data_out", data_out, '0);
        chk("rst busy", 128'(busy), 128'(1'b0));
        chk("rst in_ready", 128'(in_ready), 128'(1'b1));

        // key_reuse=1 before any expansion must still use key_in
        job("c1", C1_CT, C1_KEY, 1'b1, C1_PT, 20, 0);
        job("appb", B_CT, B_KEY, 1'b0, B_PT, 20, 0);
        chk("appb cache", dut.cache, B_RK10);
        job("cached", B_CT, '0, 1'b1, B_PT, 10, 0);
        chk("cache kept", dut.cache, B_RK10);

        // backpressure with extra in_valid offered while holding output
        @(negedge clk);
        in_valid = 1'b1; data_in = C1_CT; key_in = C1_KEY; key_reuse = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", 128'(lat), 128'(20));
        exp_hs++;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_reuse = 1'(i % 2);
            @(posedge clk);
            #1;
            chk("bp valid", 128'(out_valid), 128'(1'b1));
            chk("bp data", data_out, C1_PT);
            chk("bp in_ready", 128'(in_ready), 128'(1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0; key_reuse = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release valid", 128'(out_valid), 128'(1'b0));
        chk("bp release in_ready", 128'(in_ready), 128'(1'b1));
        chk("bp data kept", data_out, C1_PT);
        @(posedge clk);
        #1;
        chk("bp no ghost job", 128'(busy), 128'(1'b0));

        // reset during round 5
        @(negedge clk);
        in_valid = 1'b1; data_in = C1_CT; key_in = C1_KEY; key_reuse = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid round index", 128'(dut.r), 128'(5));
        reset = 1'b1;
        #1;
        chk("abort out_valid", 128'(out_valid), 128'(1'b0));
        chk("abort cache_valid", 128'(dut.cache_valid), 128'(1'b0));
        chk("abort busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort in_ready", 128'(in_ready), 128'(1'b1));
        job("post reset", C1_CT, C1_KEY, 1'b1, C1_PT, 20, 0);
        cache_key = C1_KEY;

        for (int i = 0; i < 200; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            reuse = ($urandom_range(0, 2) == 0);
            if (reuse) begin
                k    = cache_key;
                kin  = {$urandom(), $urandom(), $urandom(), $urandom()};
                elat = 10;
            end else begin
                if ($urandom_range(0, 3) == 0) k = cache_key;
                else k = {$urandom(), $urandom(), $urandom(), $urandom()};
                kin       = k;
                cache_key = k;
                elat      = 20;
            end
            job($sformatf("rnd%0d", i), enc(k, pt), kin, reuse, pt, elat,
                int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("handshake count", 128'(hs_cnt), 128'(exp_hs));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
